// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: command encodings, access sizes and FSM states for the data-memory controller
package dmem_access_ctrl_pkg;
  localparam logic [3:0] RW_IDLE  = 4'b0000;
  localparam logic [1:0] RW_STORE = 2'b01;
  localparam logic [2:0] F3_LB    = 3'b000;
  localparam logic [2:0] F3_LH    = 3'b001;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_LHU   = 3'b101;
  localparam logic [1:0] SZ_B     = 2'b00;
  localparam logic [1:0] SZ_H     = 2'b01;
  localparam logic [1:0] SZ_W     = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  function automatic logic load_ok(input logic [2:0] f);
    return f == F3_LB || f == F3_LH || f == F3_LW || f == F3_LBU || f == F3_LHU;
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed byte/half lane of a memory word and extends it
module dmem_load_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    sx = !funct3[2];
    result = funct3[1:0] == SZ_W ? word :
             funct3[1:0] == SZ_H ? {{16{sx && h[15]}}, h} : {{24{sx && b[7]}}, b};
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store controller that stalls the pipeline around one backing-memory access
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  read_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy_wait,
  output logic        misaligned,
  output logic        mem_read,
  output logic        mem_write,
  output logic [29:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);
  state_t      state, state_next;
  logic        is_load, is_store, valid, mis, start, op_load;
  logic [1:0]  size, op_offset;
  logic [2:0]  op_funct3;
  logic [31:0] wdata_fmt, aligned;
  logic [3:0]  be_fmt;
  always_comb begin
    is_load = read_write[3] && load_ok(read_write[2:0]);
    is_store = read_write[3:2] == RW_STORE && read_write[1:0] != 2'b11;
    size = read_write[1:0];
    valid = is_load || is_store;
    mis = valid && ((size == SZ_H && address[0]) || (size == SZ_W && address[1:0] != 2'b00));
    start = state == IDLE && valid && !mis;
    wdata_fmt = size == SZ_B ? {4{write_data[7:0]}} : size == SZ_H ? {2{write_data[15:0]}} : write_data;
    be_fmt = !is_store ? 4'b0000 : size == SZ_B ? 4'b0001 << address[1:0] :
             size == SZ_H ? (address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    state_next = state == IDLE ? (start ? ACCESS : IDLE) :
                 state == ACCESS ? (mem_busywait ? ACCESS : DONE) : IDLE;
    busy_wait = reset && (start || state == ACCESS);
    misaligned = reset && state == IDLE && mis;
    mem_read = reset && state == ACCESS && op_load;
    mem_write = reset && state == ACCESS && !op_load;
  end
  // the command is latched at acceptance so later changes on read_write cannot disturb the access
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      read_data <= '0;
      mem_address <= '0;
      mem_writedata <= '0;
      mem_byteenable <= '0;
      op_load <= 1'b0;
      op_funct3 <= '0;
      op_offset <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        mem_address <= address[31:2];
        mem_writedata <= wdata_fmt;
        mem_byteenable <= be_fmt;
        op_load <= is_load;
        op_funct3 <= read_write[2:0];
        op_offset <= address[1:0];
      end
      if (state == ACCESS && !mem_busywait && op_load) read_data <= aligned;
    end
  end
  dmem_load_align u_align (
    .word(mem_readdata),
    .offset(op_offset),
    .funct3(op_funct3),
    .result(aligned)
  );
endmodule
